rob_retire: RTL and testbench

In-order retirement buffer that closes the rename loop. Each renamed instruction allocates one entry at issue, carrying its architectural destination, its newly assigned physical register and the physical register it displaced. Completions arrive out of order by tag. Entries retire strictly in allocation order, one per cycle, and the retire port returns the displaced physical register to the rename free list.

---
 rtl/rob_retire_if.sv | 38 +++
 rtl/rob_retire.sv | 122 ++++++++++++
 tb/tb_rob_retire.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_if.sv
// Allocation, completion, commit and retire signals of the in-order retirement buffer.
// The pipeline drives through master; the buffer sits on slave.
interface rob_retire_if #(
  parameter int unsigned ARCH_W = 5,
  parameter int unsigned PHYS_W = 6,
  parameter int unsigned TAG_W  = 4
);
  logic              flush;
  logic              alloc_valid;
  logic [ARCH_W-1:0] alloc_rd;
  logic [PHYS_W-1:0] alloc_phys_rd;
  logic [PHYS_W-1:0] alloc_old_phys;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              complete_valid;
  logic [TAG_W-1:0]  complete_tag;
  logic              commit_valid;
  logic [ARCH_W-1:0] commit_rd;
  logic [PHYS_W-1:0] commit_phys_rd;
  logic              retire_valid;
  logic [PHYS_W-1:0] retire_phys_reg;
  logic [TAG_W:0]    count;
  logic              empty;

  modport master (
    output flush, alloc_valid, alloc_rd, alloc_phys_rd, alloc_old_phys,
           complete_valid, complete_tag,
    input  alloc_ready, alloc_tag, commit_valid, commit_rd, commit_phys_rd,
           retire_valid, retire_phys_reg, count, empty
  );

  modport slave (
    input  flush, alloc_valid, alloc_rd, alloc_phys_rd, alloc_old_phys,
           complete_valid, complete_tag,
    output alloc_ready, alloc_tag, commit_valid, commit_rd, commit_phys_rd,
           retire_valid, retire_phys_reg, count, empty
  );
endinterface

// File: rtl/rob_retire.sv
// In-order retirement buffer: allocates renamed instructions, marks out-of-order
// completions, and retires one done head entry per cycle, freeing its displaced register.
module rob_retire #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ARCH_W = 5,
  parameter int unsigned PHYS_W = 6,
  parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  rob_retire_if.slave bus
);
  localparam int unsigned PTR_W = TAG_W + 1;

  logic [DEPTH-1:0]  valid_q, done_q;
  logic [DEPTH-1:0]  valid_n, done_n;
  logic [ARCH_W-1:0] rd_q   [DEPTH];
  logic [PHYS_W-1:0] phys_q [DEPTH];
  logic [PHYS_W-1:0] old_q  [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic [PTR_W-1:0]  count_c;
  logic              ready_c;
  logic              alloc_fire, retire_fire;

  logic              commit_valid_q;
  logic [ARCH_W-1:0] commit_rd_q;
  logic [PHYS_W-1:0] commit_phys_q;
  logic              retire_valid_q;
  logic [PHYS_W-1:0] retire_phys_q;

  // Extra pointer MSB separates full (count == DEPTH) from empty.
  assign head_idx    = head_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign count_c     = tail_q - head_q;
  assign ready_c     = (count_c != PTR_W'(DEPTH));
  assign alloc_fire  = bus.alloc_valid && ready_c && !bus.flush;
  assign retire_fire = valid_q[head_idx] && done_q[head_idx] && !bus.flush;

  // Entry status: completion, then retire clears the head, then allocation claims the tail.
  always_comb begin
    valid_n = valid_q;
    done_n  = done_q;
    if (bus.complete_valid && valid_q[bus.complete_tag]) begin
      done_n[bus.complete_tag] = 1'b1;
    end
    if (retire_fire) begin
      valid_n[head_idx] = 1'b0;
      done_n[head_idx]  = 1'b0;
    end
    if (alloc_fire) begin
      valid_n[tail_idx] = 1'b1;
      done_n[tail_idx]  = 1'b0;
    end
    if (bus.flush) begin
      valid_n = '0;
      done_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_n;
      done_q  <= done_n;
      if (bus.flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (alloc_fire)  tail_q <= tail_q + PTR_W'(1);
        if (retire_fire) head_q <= head_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        phys_q[i] <= '0;
        old_q[i]  <= '0;
      end
    end else if (alloc_fire) begin
      rd_q[tail_idx]   <= bus.alloc_rd;
      phys_q[tail_idx] <= bus.alloc_phys_rd;
      old_q[tail_idx]  <= bus.alloc_old_phys;
    end
  end

  // x0 commits but frees nothing; data fields hold while their valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_phys_q  <= '0;
      retire_valid_q <= 1'b0;
      retire_phys_q  <= '0;
    end else begin
      commit_valid_q <= retire_fire;
      retire_valid_q <= retire_fire && (rd_q[head_idx] != '0);
      if (retire_fire) begin
        commit_rd_q   <= rd_q[head_idx];
        commit_phys_q <= phys_q[head_idx];
        if (rd_q[head_idx] != '0) retire_phys_q <= old_q[head_idx];
      end
    end
  end

  assign bus.alloc_ready     = ready_c;
  assign bus.alloc_tag       = tail_idx;
  assign bus.count           = count_c;
  assign bus.empty           = (count_c == '0);
  assign bus.commit_valid    = commit_valid_q;
  assign bus.commit_rd       = commit_rd_q;
  assign bus.commit_phys_rd  = commit_phys_q;
  assign bus.retire_valid    = retire_valid_q;
  assign bus.retire_phys_reg = retire_phys_q;
endmodule

// File: tb/tb_rob_retire.sv
// Directed scoreboard bench for rob_retire: expected commits are queued at allocation
// and popped whenever the buffer pulses commit_valid.
module tb_rob_retire;
  logic clk;
  logic reset;

  rob_retire_if #(.ARCH_W(5), .PHYS_W(6), .TAG_W(4)) bus ();

  rob_retire #(.DEPTH(16), .ARCH_W(5), .PHYS_W(6), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0] rd;
    logic [5:0] phys;
    logic [5:0] old;
  } exp_t;

  exp_t sb[$];
  int   n_asserts;
  int   n_fail;
  int   n_commits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any commit pulse against the oldest queued allocation.
  task automatic monitor();
    exp_t e;
    if (bus.commit_valid === 1'b1) begin
      n_commits++;
      check("commit_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
        check("commit_phys_rd", 32'(bus.commit_phys_rd), 32'(e.phys));
        check("retire_valid", 32'(bus.retire_valid), 32'(e.rd != 5'd0));
        if (e.rd != 5'd0) check("retire_phys_reg", 32'(bus.retire_phys_reg), 32'(e.old));
      end
    end else begin
      check("retire_without_commit", 32'(bus.retire_valid), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [5:0] phys,
                          input logic [5:0] old, input logic [3:0] exp_tag);
    check("alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tag));
    bus.alloc_valid    = 1'b1;
    bus.alloc_rd       = rd;
    bus.alloc_phys_rd  = phys;
    bus.alloc_old_phys = old;
    sb.push_back('{rd: rd, phys: phys, old: old});
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input logic [3:0] tag);
    bus.complete_valid = 1'b1;
    bus.complete_tag   = tag;
    tick();
    bus.complete_valid = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    n_commits = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd = '0;
    bus.alloc_phys_rd = '0;
    bus.alloc_old_phys = '0;
    bus.complete_valid = 1'b0;
    bus.complete_tag = '0;

    // Reset held two cycles, then released
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_ready", 32'(bus.alloc_ready), 32'd1);
      check("rst_tag", 32'(bus.alloc_tag), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("post_rst_empty", 32'(bus.empty), 32'd1);
    check("post_rst_commit_rd", 32'(bus.commit_rd), 32'd0);
    check("post_rst_retire_phys", 32'(bus.retire_phys_reg), 32'd0);

    // Out-of-order completion, in-order retire
    do_alloc(5'd1, 6'd32, 6'd1, 4'd0);
    do_alloc(5'd2, 6'd33, 6'd2, 4'd1);
    do_alloc(5'd3, 6'd34, 6'd3, 4'd2);
    check("ooo_count", 32'(bus.count), 32'd3);
    do_complete(4'd2);
    check("ooo_hold_a", 32'(bus.commit_valid), 32'd0);
    do_complete(4'd1);
    check("ooo_hold_b", 32'(bus.commit_valid), 32'd0);
    do_complete(4'd0);
    check("ooo_hold_c", 32'(bus.commit_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ooo_b2b_commit", 32'(bus.commit_valid), 32'd1);
    end
    tick();
    check("ooo_drained", 32'(bus.empty), 32'd1);

    // x0 destination commits without freeing
    do_alloc(5'd0, 6'd40, 6'd0, 4'd3);
    do_complete(4'd3);
    tick();
    check("x0_commit", 32'(bus.commit_valid), 32'd1);
    check("x0_retire_valid", 32'(bus.retire_valid), 32'd0);
    check("x0_retire_hold", 32'(bus.retire_phys_reg), 32'd3);
    tick();

    // Realign the tail to 0, then fill to full
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("realign_tag", 32'(bus.alloc_tag), 32'd0);
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 6'(i + 8), 6'(i + 24), 4'(i));
    check("full_ready", 32'(bus.alloc_ready), 32'd0);
    check("full_count", 32'(bus.count), 32'd16);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd = 5'd31;
    bus.alloc_phys_rd = 6'd63;
    bus.alloc_old_phys = 6'd62;
    tick();
    bus.alloc_valid = 1'b0;
    check("full_ignored_count", 32'(bus.count), 32'd16);
    check("full_ignored_tag", 32'(bus.alloc_tag), 32'd0);
    for (int i = 0; i < 4; i++) do_complete(4'(i));
    tick();
    check("partial_count", 32'(bus.count), 32'd12);
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 17), 6'(i + 48), 6'(i + 4), 4'(i));
    check("refull_count", 32'(bus.count), 32'd16);
    for (int k = 0; k < 16; k++) do_complete(4'((k + 4) % 16));
    tick();
    tick();
    check("wrap_drained", 32'(sb.size()), 32'd0);
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Allocate, complete and retire in one cycle
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 2), 6'(i + 16), 6'(i + 40), 4'(i + 4));
    do_complete(4'd4);
    check("sim_pre_count", 32'(bus.count), 32'd5);
    check("sim_prior_tail", 32'(bus.alloc_tag), 32'd9);
    bus.complete_valid = 1'b1;
    bus.complete_tag = 4'd5;
    do_alloc(5'd9, 6'd21, 6'd45, 4'd9);
    bus.complete_valid = 1'b0;
    check("sim_count", 32'(bus.count), 32'd5);
    check("sim_one_retire", 32'(bus.commit_valid), 32'd1);
    check("sim_next_tag", 32'(bus.alloc_tag), 32'd10);
    for (int t = 6; t <= 9; t++) do_complete(4'(t));
    tick();
    tick();
    check("sim_drained", 32'(sb.size()), 32'd0);

    // Flush with a colliding allocation
    for (int i = 0; i < 6; i++) do_alloc(5'(i + 10), 6'(i + 50), 6'(i + 30), 4'(i + 10));
    do_complete(4'd11);
    do_complete(4'd12);
    do_complete(4'd13);
    check("flush_pre_count", 32'(bus.count), 32'd6);
    bus.flush = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd = 5'd7;
    tick();
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    sb.delete();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_commit", 32'(bus.commit_valid), 32'd0);
    check("flush_retire", 32'(bus.retire_valid), 32'd0);
    check("flush_tag", 32'(bus.alloc_tag), 32'd0);
    do_complete(4'd11);
    tick();
    check("flush_stale_complete", 32'(bus.commit_valid), 32'd0);
    check("flush_stale_count", 32'(bus.count), 32'd0);

    // Asynchronous reset mid-operation
    do_alloc(5'd4, 6'd36, 6'd12, 4'd0);
    do_alloc(5'd5, 6'd37, 6'd13, 4'd1);
    do_complete(4'd0);
    tick();
    check("arst_pre_commit", 32'(bus.commit_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_commit", 32'(bus.commit_valid), 32'd0);
    check("arst_retire_phys", 32'(bus.retire_phys_reg), 32'd0);
    check("arst_tag", 32'(bus.alloc_tag), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("arst_ready", 32'(bus.alloc_ready), 32'd1);
    check("arst_empty", 32'(bus.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
